// File: rtl/reduction_stream_acc_pkg.sv
// Shared types and constants for the per-frame reduction accumulator.
// FRAME_LEN_EN (when defined) adds a saturating per-frame word count.
package reduction_stream_acc_pkg;
  localparam int W_DEF     = 4;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic ACC_AND_INIT = 1'b1;
  localparam logic ACC_OR_INIT  = 1'b0;
  localparam logic ACC_XOR_INIT = 1'b0;
endpackage

// File: rtl/reduction_stream_acc_if.sv
// Word-in / result-out stream bundle. out_len exists only with FRAME_LEN_EN.
interface reduction_stream_acc_if #(
  parameter int W     = 4,
  parameter int LEN_W = 8
);
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             out_and;
  logic             out_or;
  logic             out_xor;
  logic             out_valid;
  logic             out_ready;
`ifdef FRAME_LEN_EN
  logic [LEN_W-1:0] out_len;
`endif

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_and, out_or, out_xor, out_valid
`ifdef FRAME_LEN_EN
    , input out_len
`endif
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_and, out_or, out_xor, out_valid
`ifdef FRAME_LEN_EN
    , output out_len
`endif
  );
endinterface

// File: rtl/reduction_stream_acc_word.sv
// Combinational AND/OR/XOR reduction of one W-bit word.
module reduction_word #(
  parameter int W = 4
) (
  input  logic [W-1:0] w,
  output logic         r_and,
  output logic         r_or,
  output logic         r_xor
);
  assign r_and = &w;
  assign r_or  = |w;
  assign r_xor = ^w;
endmodule

// File: rtl/reduction_stream_acc.sv
// Accumulates AND/OR/XOR over all bits of a frame and holds one result per frame.
// Define FRAME_LEN_EN to also report the (saturating) word count as out_len.
module reduction_stream_acc
  import reduction_stream_acc_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  reduction_stream_acc_if.slave  s
);
  state_e state_q, state_d;
  logic   acc_and_q, acc_and_d, acc_or_q, acc_or_d, acc_xor_q, acc_xor_d;
  logic   out_and_q, out_and_d, out_or_q, out_or_d, out_xor_q, out_xor_d;
  logic   out_valid_q, out_valid_d;
  logic   w_and, w_or, w_xor;
  logic   in_ready, accept, from_acc;
  logic   c_and, c_or, c_xor;

  reduction_word #(.W(W)) u_word (
    .w     (s.in_data),
    .r_and (w_and),
    .r_or  (w_or),
    .r_xor (w_xor)
  );

`ifdef FRAME_LEN_EN
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_base, cnt_inc;
`endif

  always_comb begin
    in_ready = (state_q != ST_HOLD) || s.out_ready;
    accept   = s.in_valid && in_ready;
    // Only an open frame contributes history; IDLE/HOLD start fresh.
    from_acc = (state_q == ST_ACC);
    c_and    = (from_acc ? acc_and_q : ACC_AND_INIT) & w_and;
    c_or     = (from_acc ? acc_or_q  : ACC_OR_INIT)  | w_or;
    c_xor    = (from_acc ? acc_xor_q : ACC_XOR_INIT) ^ w_xor;

    state_d   = state_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;
    acc_xor_d = acc_xor_q;
    out_and_d = out_and_q;
    out_or_d  = out_or_q;
    out_xor_d = out_xor_q;

    if (state_q == ST_HOLD && s.out_ready) state_d = ST_IDLE;
    if (accept) begin
      if (s.in_last) begin
        out_and_d = c_and;
        out_or_d  = c_or;
        out_xor_d = c_xor;
        acc_and_d = ACC_AND_INIT;
        acc_or_d  = ACC_OR_INIT;
        acc_xor_d = ACC_XOR_INIT;
        state_d   = ST_HOLD;
      end else begin
        acc_and_d = c_and;
        acc_or_d  = c_or;
        acc_xor_d = c_xor;
        state_d   = ST_ACC;
      end
    end
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_and_q   <= ACC_AND_INIT;
      acc_or_q    <= ACC_OR_INIT;
      acc_xor_q   <= ACC_XOR_INIT;
      out_and_q   <= 1'b0;
      out_or_q    <= 1'b0;
      out_xor_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_and_q   <= acc_and_d;
      acc_or_q    <= acc_or_d;
      acc_xor_q   <= acc_xor_d;
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_xor_q   <= out_xor_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FRAME_LEN_EN
  always_comb begin
    cnt_base = from_acc ? cnt_q : '0;
    cnt_inc  = (cnt_base == LEN_MAX) ? LEN_MAX : cnt_base + 1'b1;
    cnt_d    = cnt_q;
    len_d    = len_q;
    if (accept) begin
      if (s.in_last) begin
        len_d = cnt_inc;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign s.out_len = len_q;
`endif

  assign s.in_ready  = in_ready;
  assign s.out_and   = out_and_q;
  assign s.out_or    = out_or_q;
  assign s.out_xor   = out_xor_q;
  assign s.out_valid = out_valid_q;
endmodule

// File: tb/tb_reduction_stream_acc.sv
// Bench for reduction_stream_acc: vector table, hand sequences and random traffic vs a frame-level model.
module tb_reduction_stream_acc;
  localparam int W     = 4;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reduction_stream_acc_if #(.W(W), .LEN_W(LEN_W)) bus ();
  reduction_stream_acc #(.W(W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .s(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Frame-level model: words of the open frame, and the presented result.
  logic [W-1:0] frame_q[$];
  logic m_valid, m_and, m_or, m_xor;
  int   m_len;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_valid = 1'b0;
    m_and = 1'b0; m_or = 1'b0; m_xor = 1'b0; m_len = 0;
  endtask

  // Reduce over every bit of the collected frame by counting ones.
  task automatic model_close();
    int ones, bits;
    ones = 0; bits = 0;
    foreach (frame_q[i])
      for (int b = 0; b < W; b++) begin
        bits++;
        if (frame_q[i][b]) ones++;
      end
    m_and   = (ones == bits);
    m_or    = (ones > 0);
    m_xor   = ones % 2;
    m_len   = (frame_q.size() > 255) ? 255 : frame_q.size();
    m_valid = 1'b1;
    frame_q.delete();
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, int'(bus.out_valid), int'(m_valid));
    if (m_valid) begin
      chk({tag, ".and"}, int'(bus.out_and), int'(m_and));
      chk({tag, ".or"},  int'(bus.out_or),  int'(m_or));
      chk({tag, ".xor"}, int'(bus.out_xor), int'(m_xor));
`ifdef FRAME_LEN_EN
      chk({tag, ".len"}, int'(bus.out_len), m_len);
`endif
    end
  endtask

  // One clock: drive at posedge+1, check in_ready at negedge, outputs at next posedge+1.
  task automatic cycle(input logic v, input logic l, input logic [W-1:0] d, input logic r);
    logic exp_rdy, acc;
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.in_data   = d;
    bus.out_ready = r;
    #4;
    exp_rdy = !m_valid || r;
    chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (m_valid && r) m_valid = 1'b0;
    if (acc) begin
      frame_q.push_back(d);
      if (l) model_close();
    end
    #1;
    check_out("cyc");
  endtask

  typedef struct {
    logic v; logic l; logic [W-1:0] d; logic rdy;
    logic ev; logic ea; logic eo; logic ex; int elen;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 4'hF, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 4'hF, 1, 1, 1, 1, 0, 2};
    tbl[2]  = '{1, 1, 4'h1, 1, 1, 0, 1, 1, 1};
    tbl[3]  = '{1, 0, 4'h0, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 4'h0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 4'h0, 1, 1, 0, 0, 0, 3};
    tbl[6]  = '{1, 1, 4'h7, 1, 1, 0, 1, 1, 1};
    tbl[7]  = '{1, 1, 4'h1, 1, 1, 0, 1, 1, 1};
    tbl[8]  = '{1, 1, 4'h3, 1, 1, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 4'hF, 1, 1, 1, 1, 0, 1};
    tbl[10] = '{0, 1, 4'hF, 1, 0, 0, 0, 0, 0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst.valid", int'(bus.out_valid), 0);
    chk("rst.and",   int'(bus.out_and), 0);
    chk("rst.or",    int'(bus.out_or), 0);
    chk("rst.xor",   int'(bus.out_xor), 0);
`ifdef FRAME_LEN_EN
    chk("rst.len",   int'(bus.out_len), 0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d.valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d.and", i), int'(bus.out_and), int'(tbl[i].ea));
        chk($sformatf("tbl%0d.or", i),  int'(bus.out_or),  int'(tbl[i].eo));
        chk($sformatf("tbl%0d.xor", i), int'(bus.out_xor), int'(tbl[i].ex));
`ifdef FRAME_LEN_EN
        chk($sformatf("tbl%0d.len", i), int'(bus.out_len), tbl[i].elen);
`endif
      end
    end

    // Backpressure: result held, offered word refused until out_ready rises.
    cycle(1, 1, 4'hA, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 4'h5, 0);
      chk("bp.valid", int'(bus.out_valid), 1);
      chk("bp.flags", int'({bus.out_and, bus.out_or, bus.out_xor}), 3'b010);
    end
    cycle(1, 0, 4'h5, 1);
    chk("bp.release", int'(bus.out_valid), 0);
    cycle(1, 1, 4'hC, 1);
    chk("bp.frame", int'({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}), 4'b1010);
`ifdef FRAME_LEN_EN
    chk("bp.len", int'(bus.out_len), 2);
`endif
    cycle(0, 0, 4'h0, 1);

    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            W'($urandom), $urandom_range(0, 9) < 7);

    // Reset mid-frame: partial frame must be discarded.
    cycle(0, 0, 4'h0, 1);
    cycle(1, 0, 4'hF, 1);
    cycle(1, 0, 4'hF, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst.zero", int'({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(1, 1, 4'h0, 1);
    chk("mrst.frame", int'({bus.out_valid, bus.out_and, bus.out_or, bus.out_xor}), 4'b1000);
`ifdef FRAME_LEN_EN
    chk("mrst.len", int'(bus.out_len), 1);
`endif
    cycle(0, 0, 4'h0, 1);
    chk("mrst.drop", int'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
